// File: rtl/cnt_pkg.sv
// Shared definitions for the team's counter blocks: FSM encodings, mode
// constants and the counter width helper.
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_RELOAD  = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Bits needed to hold every value 0..bound inclusive.
  function automatic int cnt_width(input int bound);
    return $clog2(bound + 1);
  endfunction

endpackage

// File: rtl/dncnt_ld.sv
// Loadable, enable-gated down counter with a registered terminal-count pulse,
// auto-reload or one-shot behaviour selected at load time.
module dncnt_ld
  import cnt_pkg::*;
#(
  parameter  int LDBND = 32,
  localparam int CW    = cnt_width(LDBND)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_mode,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc,
  output logic          o_busy
);

  localparam logic [CW-1:0] BND = CW'(LDBND);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q, tc_d;
  logic          busy_q;
  logic          mode_q, mode_d;
  logic [CW-1:0] load_clamped;

  assign load_clamped = (i_load_val > BND) ? BND : i_load_val;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    tc_d    = 1'b0;

    if (i_load) begin
      cnt_d   = load_clamped;
      mode_d  = i_mode;
      state_d = (i_mode == MODE_ONESHOT && load_clamped == '0) ? DONE : RUN;
    end else if (state_q == RUN && i_en) begin
      if (cnt_q == '0) begin
        // Only auto-reload can sit at zero in RUN; the wrap is silent.
        if (mode_q == MODE_RELOAD) cnt_d = BND;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          tc_d = 1'b1;
          if (mode_q == MODE_ONESHOT) state_d = DONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      mode_q  <= MODE_RELOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == RUN);
      mode_q  <= mode_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_tc   = tc_q;
  assign o_busy = busy_q;

endmodule

// File: doc/dncnt_ld.md
Name: dncnt_ld

Overview:
Loadable, enable-gated down counter with terminal-count pulse. It is the count-down counterpart of the team's wrapping up counter and is used for timeouts, delay timers and burst-length tracking.
Two modes:
- Auto-reload: wraps 0 -> LDBND.
- One-shot: stops at 0 and holds until reloaded.
A 3-state control FSM governs when counting is allowed.

Parameters:
LDBND, 32, maximum count and reload value; counter width CW = $clog2(LDBND+1) (6 bits at default).

Ports:
i_clk  input  1  clock; all state changes on rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_load  input  1  load request; highest priority after reset.
i_load_val  input  CW  value to load; clamped to LDBND.
i_mode  input  1  sampled only on load: 0 = auto-reload, 1 = one-shot.
i_en  input  1  count enable; one decrement per cycle while high in RUN.
o_cnt  output  CW  current count (registered).
o_tc  output  1  registered terminal-count pulse, 1 cycle.
o_busy  output  1  registered, high while FSM is in RUN.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values (immediate on i_rst assertion, independent of clock): o_cnt=0, o_tc=0, o_busy=0, FSM=IDLE, mode_q=0.
- Reset mid-operation: count, mode and FSM are discarded. The block resumes only after a new load following i_rst deassertion.
- FSM states:
  - IDLE: after reset. Ignores i_en.
  - RUN: decrements while i_en=1.
  - DONE: one-shot reached 0. Holds o_cnt=0 and ignores i_en.
- Transitions:
  - Any state + i_load=1 -> RUN.
  - Exception: one-shot load of value 0 -> DONE.
  - RUN + one-shot + decrement from 1 -> DONE.
  - No other transitions. Auto-reload never leaves RUN except by reset.
- Load, 1-cycle latency: edge with i_load=1 gives o_cnt = min(i_load_val, LDBND) after that edge. mode_q <= i_mode. o_tc=0 that cycle.
- Decrement (RUN, i_en=1, i_load=0):
  - o_cnt>0: o_cnt <= o_cnt-1.
  - o_cnt==0 in auto-reload: o_cnt <= LDBND. This wrap does not pulse o_tc.
- o_tc: registered. High exactly for the cycle in which o_cnt==0 as the result of a decrement from 1. It is never high after a load or reset. A held zero (DONE, or i_en low at 0) does not re-pulse.
- i_en low in RUN: o_cnt, FSM and mode hold; o_tc=0.
- Simultaneous load and decrement-to-zero: load wins. o_cnt = loaded value, no o_tc.
- Loaded value 0 in auto-reload: RUN. The next enabled edge gives o_cnt=LDBND with no o_tc.
- o_busy: high in the cycle after entering RUN. Low in the cycle where DONE is entered, i.e. the same cycle as o_tc.
- Width rules:
  - All compares and the clamp are done at CW bits, with i_load_val treated as unsigned.
  - LDBND must fit in CW; this follows from the CW formula.
  - No intermediate wider than CW+1.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package cnt_pkg:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Mode constants: MODE_RELOAD=1'b0, MODE_ONESHOT=1'b1.
  - Width helper function, shared with the up counter.
- No sub-module. A single module holds the FSM, the count register and the tc register.

Test Plan:
1. Reset and IDLE: assert i_rst mid-cycle -> o_cnt=0, o_tc=0, o_busy=0 immediately. Deassert and hold i_en=1 with no load for 10 cycles -> o_cnt stays 0, o_busy=0.
2. Auto-reload: load 3 with i_mode=0, then i_en=1 -> o_cnt 3,2,1,0,32,31. o_tc=1 only in the o_cnt=0 cycle. o_busy stays 1.
3. One-shot: load 5 with i_mode=1, i_en=1 -> o_cnt 5..0. o_tc=1 and o_busy=0 in the 0 cycle. o_cnt then holds 0 with no further o_tc for 5 more cycles.
4. Clamp and zero load:
   - Load 40 -> o_cnt=32.
   - Load 0 in one-shot -> DONE, o_busy=0, no o_tc.
   - Load 0 in auto-reload, i_en=1 -> next o_cnt=32, no o_tc.
5. Enable gating and load priority:
   - Load 6; drop i_en at o_cnt=4 for 3 cycles -> o_cnt holds at 4.
   - Resume; at o_cnt=1 assert i_load with value 7 -> o_cnt=7, o_tc stays 0.
6. Reset mid-run: one-shot load 20; assert i_rst at o_cnt=12 between edges -> o_cnt=0, FSM=IDLE at once. Release i_rst -> no counting until the next load.
